// File: rtl/data_mem_responder.sv
// Single-ported data RAM plus a memory-mapped LED register behind a
// valid/ready request channel; one request in flight, three-state FSM.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] LED_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] led
);

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [15:0] led_q, led_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          led_hit;
  logic          ram_hit;
  logic          fault;
  logic          ram_wr;
  logic [AW-1:0] idx;
  logic [31:0]   ram_word;
  logic [31:0]   wmerge;

  assign idx      = addr_q[AW+1:2];
  assign led_hit  = (addr_q == LED_ADDR);
  assign ram_hit  = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
  assign fault    = (addr_q[1:0] != 2'b00) || (!led_hit && !ram_hit);
  assign ram_word = mem_q[idx];
  assign ram_wr   = (state_q == ACCESS) && we_q && !fault && !led_hit;

  // RAM is deliberately not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem_q[idx] <= wmerge;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    led_d   = led_q;
    wmerge  = ram_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) begin
        wmerge[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          we_d    = req_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = fault;
        rdata_d = '0;
        if (!fault && !we_q) begin
          rdata_d = led_hit ? {16'h0000, led_q} : ram_word;
        end
        if (!fault && we_q && led_hit) begin
          if (be_q[0]) led_d[7:0]  = wdata_q[7:0];
          if (be_q[1]) led_d[15:8] = wdata_q[15:8];
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid ? err_q : 1'b0;
  assign led       = led_q;

endmodule
